// File: rtl/sprite_line_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | sprite_line_fetch                                                          |
// | Per-scanline sequencer: reads two pattern words per icon and broadcasts    |
// | them with per-icon load strobes. Option: SPRITE_FETCH_SKIP_EN skips icons  |
// | that are not visible on the next line.                                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sprite_line_fetch #(
    parameter int NUM_ICONS   = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     line_start,
    input  logic [12*NUM_ICONS-1:0]  icon_addr,
    input  logic [NUM_ICONS-1:0]     icon_vis,
    output logic                     mem_rd,
    output logic [11:0]              mem_addr,
    input  logic [31:0]              mem_data,
    output logic [31:0]              fetch_data,
    output logic [2*NUM_ICONS-1:0]   ds,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [4:0] C_LAST_ICON = 5'(NUM_ICONS - 1);

    logic [1:0]             state_q, state_d;
    logic [4:0]             icon_q, icon_d;
    logic                   word_q, word_d;
    logic                   mem_rd_q, mem_rd_d;
    logic [11:0]            mem_addr_q, mem_addr_d;
    logic                   done_q, done_d;
    logic [MEM_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [MEM_LATENCY-1:0] tag_word_q, tag_word_d;
    logic [4:0]             tag_icon_q [MEM_LATENCY];
    logic [4:0]             tag_icon_d [MEM_LATENCY];

    logic                   w_first_found, w_next_found, w_pipe_busy, w_sel_word;
    logic [4:0]             w_first_idx, w_next_idx, w_sel_idx;
    logic [8:0]             w_sel_base;
    logic [3*NUM_ICONS-1:0] w_addr_lsb;
    logic                   w_unused;

    for (genvar g = 0; g < NUM_ICONS; g++) begin : g_lsb
        assign w_addr_lsb[3*g +: 3] = icon_addr[12*g +: 3];
    end

`ifdef SPRITE_FETCH_SKIP_EN
    logic [NUM_ICONS-1:0] vis_q, vis_d;

    assign w_unused = ^w_addr_lsb;

    // Descending scan so the lowest qualifying index wins.
    always_comb begin
        w_first_found = 1'b0;
        w_first_idx   = 5'd0;
        w_next_found  = 1'b0;
        w_next_idx    = 5'd0;
        for (int i = NUM_ICONS - 1; i >= 0; i--) begin
            if (icon_vis[i]) begin
                w_first_found = 1'b1;
                w_first_idx   = 5'(i);
            end
            if (vis_q[i] && (5'(i) > icon_q)) begin
                w_next_found = 1'b1;
                w_next_idx   = 5'(i);
            end
        end
    end
`else
    assign w_unused = ^{w_addr_lsb, icon_vis};

    always_comb begin
        w_first_found = 1'b1;
        w_first_idx   = 5'd0;
        w_next_found  = (icon_q != C_LAST_ICON);
        w_next_idx    = icon_q + 5'd1;
    end
`endif

    always_comb begin
        w_sel_idx  = (state_q == S_IDLE) ? w_first_idx : (word_q ? w_next_idx : icon_q);
        w_sel_word = (state_q == S_ISSUE) && !word_q;
        w_sel_base = 9'd0;
        for (int i = 0; i < NUM_ICONS; i++) begin
            if (w_sel_idx == 5'(i)) begin
                w_sel_base = icon_addr[12*i+3 +: 9];
            end
        end
    end

    // Pipeline will still hold a tag next cycle.
    always_comb begin
        w_pipe_busy = mem_rd_q;
        for (int i = 0; i < MEM_LATENCY - 1; i++) begin
            w_pipe_busy = w_pipe_busy | tag_vld_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (line_start && w_first_found) state_d = S_ISSUE;
            S_ISSUE: if (word_q && !w_next_found)     state_d = S_DRAIN;
            S_DRAIN: if (!w_pipe_busy)                state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        icon_d     = icon_q;
        word_d     = word_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        done_d     = 1'b0;
`ifdef SPRITE_FETCH_SKIP_EN
        vis_d      = vis_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (line_start) begin
`ifdef SPRITE_FETCH_SKIP_EN
                    vis_d = icon_vis;
`endif
                    if (w_first_found) begin
                        icon_d     = w_first_idx;
                        word_d     = 1'b0;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = {w_sel_base, w_sel_word, 2'b00};
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (!word_q) begin
                    word_d     = 1'b1;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = {w_sel_base, w_sel_word, 2'b00};
                end else if (w_next_found) begin
                    icon_d     = w_next_idx;
                    word_d     = 1'b0;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = {w_sel_base, w_sel_word, 2'b00};
                end
            end
            S_DRAIN: begin
                if (!w_pipe_busy) done_d = 1'b1;
            end
            default: ;
        endcase

        tag_vld_d[0]  = mem_rd_q;
        tag_word_d[0] = word_q;
        tag_icon_d[0] = icon_q;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_word_d[i] = tag_word_q[i-1];
            tag_icon_d[i] = tag_icon_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icon_q     <= 5'd0;
            word_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= 12'd0;
            done_q     <= 1'b0;
            tag_vld_q  <= '0;
            tag_word_q <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) tag_icon_q[i] <= 5'd0;
`ifdef SPRITE_FETCH_SKIP_EN
            vis_q      <= '0;
`endif
        end else begin
            icon_q     <= icon_d;
            word_q     <= word_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            done_q     <= done_d;
            tag_vld_q  <= tag_vld_d;
            tag_word_q <= tag_word_d;
            for (int i = 0; i < MEM_LATENCY; i++) tag_icon_q[i] <= tag_icon_d[i];
`ifdef SPRITE_FETCH_SKIP_EN
            vis_q      <= vis_d;
`endif
        end
    end

    always_comb begin
        ds = '0;
        for (int i = 0; i < NUM_ICONS; i++) begin
            ds[2*i]   = tag_vld_q[MEM_LATENCY-1] && (tag_icon_q[MEM_LATENCY-1] == 5'(i)) &&
                        !tag_word_q[MEM_LATENCY-1];
            ds[2*i+1] = tag_vld_q[MEM_LATENCY-1] && (tag_icon_q[MEM_LATENCY-1] == 5'(i)) &&
                        tag_word_q[MEM_LATENCY-1];
        end
    end

    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign done       = done_q;
    assign busy       = (state_q != S_IDLE);
    assign overrun    = line_start && busy;
    assign fetch_data = mem_data;

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sprite_line_fetch                                                       |
// | Directed vector bench for sprite_line_fetch at latency 1 and 3.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sprite_line_fetch;

    typedef struct {
        logic        rd;
        logic [11:0] addr;
        logic [15:0] ds;
        logic        busy;
        logic        done;
        logic [31:0] data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ls1 = 1'b0;
    logic        ls3 = 1'b0;
    logic [95:0] icon_addr;
    logic [7:0]  icon_vis;

    logic        rd1, busy1, done1, ov1, rd3, busy3, done3, ov3;
    logic [11:0] addr1, addr3;
    logic [31:0] md1, md3, fd1, fd3;
    logic [15:0] ds1, ds3;
    logic [11:0] mp1;
    logic [11:0] mp3 [3];

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    sprite_line_fetch #(.NUM_ICONS(8), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .line_start(ls1), .icon_addr(icon_addr),
        .icon_vis(icon_vis), .mem_rd(rd1), .mem_addr(addr1), .mem_data(md1),
        .fetch_data(fd1), .ds(ds1), .busy(busy1), .done(done1), .overrun(ov1)
    );

    sprite_line_fetch #(.NUM_ICONS(8), .MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .line_start(ls3), .icon_addr(icon_addr),
        .icon_vis(icon_vis), .mem_rd(rd3), .mem_addr(addr3), .mem_data(md3),
        .fetch_data(fd3), .ds(ds3), .busy(busy3), .done(done3), .overrun(ov3)
    );

    // Memory models: latency 1 returns a tagged address, latency 3 returns the address.
    always @(posedge clk) begin
        mp1    <= addr1;
        mp3[0] <= addr3;
        mp3[1] <= mp3[0];
        mp3[2] <= mp3[1];
    end
    assign md1 = {20'hA5A5A, mp1};
    assign md3 = {20'h00000, mp3[2]};

    function automatic logic [11:0] ia(input int i);
        return (i == 3) ? 12'h2A4 : 12'(12'h807 + i * 16);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic build(input logic [7:0] vis, input int lat);
        int ri[$];
        int rw[$];
        int n, dc, k;
        logic [11:0] a;
        vec_t v;
        tbl.delete();
        for (int i = 0; i < 8; i++) begin
            if (vis[i]) begin
                ri.push_back(i); rw.push_back(0);
                ri.push_back(i); rw.push_back(1);
            end
        end
        n  = ri.size();
        dc = (n == 0) ? 1 : n + lat + 1;
        for (int c = 1; c <= dc + 1; c++) begin
            v.rd   = (c - 1 < n);
            v.addr = 12'h000;
            if (v.rd) begin
                a      = ia(ri[c-1]);
                v.addr = {a[11:3], 1'(rw[c-1]), 2'b00};
            end
            k      = c - 1 - lat;
            v.ds   = 16'h0000;
            v.data = 32'h0;
            if (k >= 0 && k < n) begin
                a      = ia(ri[k]);
                v.ds   = 16'(1) << (2 * ri[k] + rw[k]);
                v.data = (lat == 1) ? {20'hA5A5A, a[11:3], 1'(rw[k]), 2'b00}
                                    : {20'h00000, a[11:3], 1'(rw[k]), 2'b00};
            end
            v.busy = (c < dc);
            v.done = (c == dc);
            tbl.push_back(v);
        end
    endtask

    task automatic run_table(input int sel, input int ov_cyc);
        logic        a_rd, a_busy, a_done, a_ov;
        logic [11:0] a_addr;
        logic [15:0] a_ds;
        logic [31:0] a_fd;
        step();
        if (sel == 0) ls1 = 1'b1; else ls3 = 1'b1;
        for (int c = 1; c <= tbl.size(); c++) begin
            @(posedge clk);
            #1;
            if (sel == 0) ls1 = (c == ov_cyc); else ls3 = (c == ov_cyc);
            #1;
            if (sel == 0) begin
                a_rd = rd1; a_addr = addr1; a_ds = ds1; a_busy = busy1;
                a_done = done1; a_ov = ov1; a_fd = fd1;
            end else begin
                a_rd = rd3; a_addr = addr3; a_ds = ds3; a_busy = busy3;
                a_done = done3; a_ov = ov3; a_fd = fd3;
            end
            chk("mem_rd", c, 32'(a_rd), 32'(tbl[c-1].rd));
            if (tbl[c-1].rd) chk("mem_addr", c, 32'(a_addr), 32'(tbl[c-1].addr));
            chk("ds", c, 32'(a_ds), 32'(tbl[c-1].ds));
            chk("busy", c, 32'(a_busy), 32'(tbl[c-1].busy));
            chk("done", c, 32'(a_done), 32'(tbl[c-1].done));
            chk("overrun", c, 32'(a_ov), 32'(c == ov_cyc));
            if (tbl[c-1].ds != 16'h0) chk("fetch_data", c, a_fd, tbl[c-1].data);
        end
        ls1 = 1'b0;
        ls3 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) icon_addr[12*i +: 12] = ia(i);
        icon_vis = 8'hFF;
        rst_n    = 1'b0;
        step();
        step();
        chk("rst_mem_rd", 0, 32'({rd1, rd3}), 32'h0);
        chk("rst_mem_addr", 0, 32'({addr1, addr3}), 32'h0);
        chk("rst_ds", 0, 32'({ds1, ds3}), 32'h0);
        chk("rst_busy_done_ov", 0, 32'({busy1, busy3, done1, done3, ov1, ov3}), 32'h0);
        rst_n = 1'b1;
        step();

        // Full pass at latency 1, then latency 3.
        build(8'hFF, 1);
        run_table(0, 0);
        build(8'hFF, 3);
        run_table(1, 0);

        // Repeated line_start mid-pass.
        build(8'hFF, 1);
        run_table(0, 5);

        // Reset asserted mid-pass for two cycles.
        step();
        ls1 = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            ls1 = 1'b0;
        end
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", 6, 32'({rd1, ds1, busy1, done1}), 32'h0);
        step();
        #1;
        chk("midrst_outs", 7, 32'({rd1, ds1, busy1, done1}), 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("postrst_outs", 8, 32'({rd1, ds1, busy1, done1}), 32'h0);
        run_table(0, 0);

`ifdef SPRITE_FETCH_SKIP_EN
        icon_vis = 8'b1000_0001;
        build(8'b1000_0001, 1);
        run_table(0, 0);
        icon_vis = 8'h00;
        build(8'h00, 1);
        run_table(0, 0);
`else
        icon_vis = 8'h00;
        build(8'hFF, 1);
        run_table(0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end of test");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/sprite_line_fetch.md
# sprite_line_fetch

Per-scanline fetch sequencer that loads each sprite icon's two pixel words for the upcoming line from sprite pattern memory. It sits directly upstream of the icon array: it reads pattern memory at each icon's requested address and broadcasts the returned word with a per-icon, per-word load strobe (`ds`). A fetch pass runs during horizontal blanking, started by a line pulse from video timing.

## Interface
- `NUM_ICONS`, default 8: icons served per line, range 1-32.
- `MEM_LATENCY`, default 1: cycles from `mem_rd` to valid `mem_data`, range 1-4, fixed.

- `clk`  in  1  pixel/system clock.
- `rst_n`  in  1  reset; one clock, reset asynchronous and active-low.
- `line_start`  in  1  one-cycle pulse that starts a fetch pass.
- `icon_addr`  in  12*NUM_ICONS  flattened per-icon `sprite_addr`; icon i at bits [12*i+11:12*i].
- `icon_vis`  in  NUM_ICONS  icon i vertically visible on the next line.
- `mem_rd`  out  1  pattern memory read enable.
- `mem_addr`  out  12  pattern memory byte address.
- `mem_data`  in  32  read data, valid `MEM_LATENCY` cycles after `mem_rd`.
- `fetch_data`  out  32  broadcast word to all icons.
- `ds`  out  2*NUM_ICONS  load strobes; bit 2i = icon i word 0, bit 2i+1 = icon i word 1.
- `busy`  out  1  pass in progress.
- `done`  out  1  one-cycle pulse at end of pass.
- `overrun`  out  1  one-cycle pulse when `line_start` arrives while busy.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: on `line_start`, go to ISSUE, icon counter = 0, word = 0.
- ISSUE: one read per cycle; `mem_addr = {icon_addr[i][11:3], word, 2'b00}`, so bit 2 comes from the fetcher, never from the icon. Order: icon 0 word 0, icon 0 word 1, icon 1 word 0, and so on. After the last read, go to DRAIN.
- Tag pipeline: a `MEM_LATENCY`-deep shift register carries valid, icon index and word.
- When the tag exits the pipeline: `fetch_data = mem_data` and exactly one `ds` bit is high, in the same cycle. `fetch_data` is combinational pass-through of `mem_data`. At most one `ds` bit is high in any cycle.
- DRAIN: wait until the pipeline is empty, pulse `done`, go to IDLE.
- `busy` is high in ISSUE and DRAIN.
- `line_start` while `busy`: ignored; pass continues unchanged; `overrun` pulses for 1 cycle.
- Reset, including mid-pass: FSM = IDLE, pipeline cleared, no further `ds`. Reset values of all outputs: `mem_rd` 0, `mem_addr` 0, `ds` 0, `busy` 0, `done` 0, `overrun` 0. `fetch_data` follows `mem_data`.
- Counter widths: icon counter is 5 bits; the terminal compare uses `NUM_ICONS-1` with no wrap past it.

## Timing
- `line_start` at cycle T: first `mem_rd` at T+1.
- Read k (0-based) is issued at T+1+k.
- The strobe for read k is at T+1+k+`MEM_LATENCY`.
- Full pass, no skipping: 2*NUM_ICONS reads; `done` at T+2*NUM_ICONS+`MEM_LATENCY`+1; `busy` falls the same cycle `done` rises.
- Reads are back-to-back; `mem_rd` is registered.
- With NUM_ICONS=8 and `MEM_LATENCY`=1 a pass takes 18 cycles, which fits in horizontal blanking.

## Configuration
- `SPRITE_FETCH_SKIP_EN` defined: icons with `icon_vis[i]=0` are skipped entirely (no read, no `ds`). The skip costs no cycle: the next visible icon's read issues the following cycle. If no icon is visible, `done` pulses at T+1 and `mem_rd` never rises. `icon_vis` is sampled on `line_start`.
- Not defined: `icon_vis` is ignored and every icon is fetched.

## Test plan
- Reset then a single `line_start` with NUM_ICONS=8, `MEM_LATENCY`=1, `icon_addr[3]`=12'h2A4 -> reads to 12'h2A0 at T+7 and 12'h2A4 at T+8; `ds[6]` at T+8 with data from 12'h2A0; `ds[7]` at T+9; `done` at T+18.
- `MEM_LATENCY`=3, memory returns address as data -> every strobed `fetch_data` equals its own `mem_addr`; 16 strobes total, one per cycle; `done` at T+20.
- `line_start` repeated at T+5 -> `overrun` pulses at T+5; the strobe sequence is identical to a single pass.
- `rst_n` low at T+6 for 2 cycles -> `ds`, `busy` and `mem_rd` are 0 from the assertion onward; a new `line_start` runs a full clean pass.
- `SPRITE_FETCH_SKIP_EN`, `icon_vis`=8'b1000_0001 -> exactly 4 reads (icons 0 and 7) at T+1..T+4; `done` at T+6. With `icon_vis`=0 -> `done` at T+1.
- Without the macro, `icon_vis`=0 -> all 16 reads occur.
